// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment scan decoder: the sixteen
//   active-low segment patterns (bit6=a ... bit0=g), the blank pattern
//   and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_lut.sv
// seg7_pattern_lut
//   Combinational lookup from an active-low segment pattern to its hex value.
//   Ports:
//     seg   in  7  active-low segments, bit6=a ... bit0=g
//     value out 4  decoded hex value (0 when not a digit pattern)
//     hit   out 1  pattern is one of the sixteen digit glyphs
//     blank out 1  pattern is all segments off
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    hit   = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_A:     value = 4'hA;
      SEG_B:     value = 4'hB;
      SEG_C:     value = 4'hC;
      SEG_D:     value = 4'hD;
      SEG_E:     value = 4'hE;
      SEG_F:     value = 4'hF;
      SEG_BLANK: begin
        hit   = 1'b0;
        blank = 1'b1;
      end
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Snoops a multiplexed seven-segment display drive (anode strobes plus
//   segment lines, both active-low) and recovers the value shown on each
//   digit. A pattern is captured once it has been stable for STABLE_CYCLES.
//   Optional feature: define SEG7_ERR_CNT_EN to add the err_cnt output.
//   Ports:
//     clk        in   1         clock, rising edge
//     rst_n      in   1         async active-low reset
//     an         in   DIGITS    anode strobes, bit i low selects digit i
//     seg        in   7         segments, bit6=a ... bit0=g, active-low
//     clr        in   1         synchronous clear of captured digits
//     digit_val  out  4*DIGITS  last captured value, digit i in [4i+3:4i]
//     digit_ok   out  DIGITS    digit i holds a valid decoded value
//     upd_valid  out  1         single-cycle capture pulse
//     upd_idx    out  3         digit index of the capture
//     upd_val    out  4         decoded value of the capture (0 if not a digit)
//     upd_err    out  1         capture pattern unrecognised
//     err_cnt    out  8         (SEG7_ERR_CNT_EN only) saturating error count
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no single anode selected, nothing to track
//   ST_TRACK | one anode selected, counting cycles of unchanged {an,seg}
//   ST_HOLD  | current pair already captured, waiting for it to change
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS-1:0]   an,
  input  logic [6:0]          seg,
  input  logic                clr,
  output logic [4*DIGITS-1:0] digit_val,
  output logic [DIGITS-1:0]   digit_ok,
  output logic                upd_valid,
  output logic [2:0]          upd_idx,
  output logic [3:0]          upd_val,
  output logic                upd_err
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0] an_m, an_s, an_q;
  logic [6:0]        seg_m, seg_s, seg_q;
  logic [DIGITS-1:0] an_sel;
  logic              an_ok;
  logic              same;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              capture;
  logic [2:0]        cap_idx;

  logic [3:0]        lut_val;
  logic              lut_hit;
  logic              lut_blank;

  // Two-flop synchroniser, then a registered copy used to detect changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_m  <= '0;
      an_s  <= '0;
      seg_m <= '0;
      seg_s <= '0;
      an_q  <= '0;
      seg_q <= '0;
    end else begin
      an_m  <= an;
      an_s  <= an_m;
      seg_m <= seg;
      seg_s <= seg_m;
      an_q  <= an_s;
      seg_q <= seg_s;
    end
  end

  // Exactly one anode low: non-zero and a power of two once inverted.
  assign an_sel = ~an_s;
  assign an_ok  = (an_sel != '0) && ((an_sel & (an_sel - DIGITS'(1))) == '0);
  assign same   = ({an_s, seg_s} == {an_q, seg_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (an_ok) state_nxt = ST_TRACK;
      end
      ST_TRACK: begin
        if (!an_ok) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (!same) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_nxt = '0;
        if (!an_ok)     state_nxt = ST_IDLE;
        else if (!same) state_nxt = ST_TRACK;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A capture only fires after {an,seg} matched its copy, so the copy is
  // the pattern being captured.
  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) cap_idx = 3'(i);
    end
  end

  seg7_pattern_lut u_lut (
    .seg   (seg_q),
    .value (lut_val),
    .hit   (lut_hit),
    .blank (lut_blank)
  );

  // clr takes priority over a coincident capture for the stored digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val <= '0;
      digit_ok  <= '0;
    end else if (clr) begin
      digit_val <= '0;
      digit_ok  <= '0;
    end else if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_idx == 3'(i)) begin
          if (lut_hit) begin
            digit_val[4*i +: 4] <= lut_val;
            digit_ok[i]         <= 1'b1;
          end else begin
            digit_ok[i]         <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_val   <= '0;
      upd_err   <= 1'b0;
    end else begin
      upd_valid <= capture;
      if (capture) begin
        upd_idx <= cap_idx;
        upd_val <= lut_hit ? lut_val : 4'h0;
        upd_err <= !lut_hit && !lut_blank;
      end
    end
  end

`ifdef SEG7_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (capture && !lut_hit && !lut_blank && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
//   Scoreboard bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=16).
//   Optional: SEG7_ERR_CNT_EN also checks err_cnt.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int S      = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic [3:0]  an    = 4'hF;
  logic [6:0]  seg   = 7'h7F;
  logic [15:0] digit_val;
  logic [3:0]  digit_ok;
  logic        upd_valid;
  logic [2:0]  upd_idx;
  logic [3:0]  upd_val;
  logic        upd_err;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .an        (an),
    .seg       (seg),
    .clr       (clr),
    .digit_val (digit_val),
    .digit_ok  (digit_ok),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_val   (upd_val),
    .upd_err   (upd_err)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [3:0] val;
    logic       err;
    logic [15:0] dval;
    logic [3:0] dok;
    int         ecnt;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
  } pend_t;

  exp_t  expq[$];
  pend_t pendq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses_seen = 0;
  int pulses_exp = 0;
  int last_pulse_cyc = 0;
  int rel_cyc = 0;

  // Reference model state
  logic [3:0] m_val [4];
  logic [3:0] m_ok;
  int         m_ecnt;
  logic [3:0] cur_an;
  logic [6:0] cur_seg;
  logic       cur_valid = 1'b0;
  logic       run_pend = 1'b0;
  int         run_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [3:0] a);
    int n = 0;
    int p = -1;
    for (int k = 0; k < 4; k++) begin
      if (!a[k]) begin
        n++;
        p = k;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  function automatic void decode(input logic [6:0] s, output logic [3:0] v,
                                 output logic hit, output logic blank);
    v     = 4'h0;
    hit   = 1'b0;
    blank = (s == 7'h7F);
    for (int k = 0; k < 16; k++) begin
      if (pat[k] == s) begin
        v   = 4'(k);
        hit = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] m_dval();
    return {m_val[3], m_val[2], m_val[1], m_val[0]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_val[k] = 4'h0;
    m_ok   = 4'h0;
    m_ecnt = 0;
  endtask

  // Applied right after each rising edge, using the clr value that edge saw.
  task automatic model_edge();
    pend_t      p;
    exp_t       e;
    int         i;
    logic [3:0] v;
    logic       hit, blank;
    logic       cap = 1'b0;
    if (pendq.size() > 0 && pendq[0].cyc == cyc) begin
      p = pendq.pop_front();
      i = idx_of(p.an);
      decode(p.seg, v, hit, blank);
      if (hit) begin
        m_val[i] = v;
        m_ok[i]  = 1'b1;
      end else begin
        m_ok[i]  = 1'b0;
      end
      e.cyc = cyc;
      e.idx = 3'(i);
      e.val = hit ? v : 4'h0;
      e.err = !hit && !blank;
      if (e.err && m_ecnt < 255) m_ecnt++;
      cap = 1'b1;
    end
    if (clr) model_clear();
    if (cap) begin
      e.dval = m_dval();
      e.dok  = m_ok;
      e.ecnt = m_ecnt;
      expq.push_back(e);
      pulses_exp++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
  endtask

  // A new {an,seg} run: a pending capture of the previous run survives only
  // if that run was held long enough to pass through the synchroniser.
  task automatic start_run(input logic [3:0] a, input logic [6:0] s);
    pend_t p;
    if (run_pend && run_len < S + 1) void'(pendq.pop_back());
    cur_an    = a;
    cur_seg   = s;
    cur_valid = 1'b1;
    run_len   = 0;
    run_pend  = 1'b0;
    if (idx_of(a) >= 0) begin
      p.cyc = cyc + S + 3;
      p.an  = a;
      p.seg = s;
      pendq.push_back(p);
      run_pend = 1'b1;
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [6:0] s, input int len, input int clr_at);
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      if (j == 1 && (!cur_valid || a != cur_an || s != cur_seg)) start_run(a, s);
      an  = a;
      seg = s;
      clr = (j == clr_at);
      step();
      run_len++;
    end
  endtask

  task automatic rst_pulse(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    clr   = 1'b0;
    #1;
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_idx",   32'(upd_idx),   32'd0);
    chk("rst_upd_val",   32'(upd_val),   32'd0);
    chk("rst_upd_err",   32'(upd_err),   32'd0);
    chk("rst_digit_val", 32'(digit_val), 32'd0);
    chk("rst_digit_ok",  32'(digit_ok),  32'd0);
`ifdef SEG7_ERR_CNT_EN
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
`endif
    pendq.delete();
    model_clear();
    cur_valid = 1'b0;
    run_pend  = 1'b0;
    repeat (n) step();
    @(negedge clk);
    rst_n   = 1'b1;
    rel_cyc = cyc;
    start_run(an, seg);
    step();
    run_len++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && upd_valid) begin
      pulses_seen++;
      last_pulse_cyc = cyc;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got upd_valid=1 idx=%0d val=%0h, required no pulse (cycle %0d)",
                 upd_idx, upd_val, cyc);
      end else begin
        e = expq.pop_front();
        chk("pulse_cycle", 32'(cyc),       32'(e.cyc));
        chk("upd_idx",     32'(upd_idx),   32'(e.idx));
        chk("upd_val",     32'(upd_val),   32'(e.val));
        chk("upd_err",     32'(upd_err),   32'(e.err));
        chk("digit_val",   32'(digit_val), 32'(e.dval));
        chk("digit_ok",    32'(digit_ok),  32'(e.dok));
`ifdef SEG7_ERR_CNT_EN
        chk("err_cnt",     32'(err_cnt),   32'(e.ecnt));
`endif
      end
    end
  end

  initial begin
    int p0;
    logic [3:0] ra;
    logic [6:0] rs;
    int rl, rc, r;

    model_clear();
    rst_pulse(3);

    // Single capture of '2' on digit 0
    p0 = pulses_seen;
    apply(4'b1110, pat[2], 20, 0);
    #1;
    chk("t1_pulses",   32'(pulses_seen - p0), 32'd1);
    chk("t1_digit0",   32'(digit_val[3:0]),   32'h2);
    chk("t1_ok0",      32'(digit_ok[0]),      32'd1);

    // Scan 1, A, d, F across four digits
    p0 = pulses_seen;
    apply(4'b1110, pat[1],  30, 0);
    apply(4'b1101, pat[10], 30, 0);
    apply(4'b1011, pat[13], 30, 0);
    apply(4'b0111, pat[15], 30, 0);
    #1;
    chk("t2_pulses",    32'(pulses_seen - p0), 32'd4);
    chk("t2_digit_val", 32'(digit_val),        32'hFDA1);
    chk("t2_digit_ok",  32'(digit_ok),         32'hF);

    // Unrecognised pattern on digit 2
    p0 = pulses_seen;
    apply(4'b1011, 7'b1010101, 25, 0);
    #1;
    chk("t3_pulses",   32'(pulses_seen - p0), 32'd1);
    chk("t3_ok2",      32'(digit_ok[2]),      32'd0);
    chk("t3_upd_err",  32'(upd_err),          32'd1);
    chk("t3_upd_idx",  32'(upd_idx),          32'd2);
`ifdef SEG7_ERR_CNT_EN
    chk("t3_err_cnt",  32'(err_cnt),          32'd1);
`endif

    // Two anodes low with segments toggling every 8 cycles: never captured
    p0 = pulses_seen;
    for (int k = 0; k < 6; k++) apply(4'b1100, (k % 2) ? pat[8] : pat[0], 8, 0);
    #1;
    chk("t4_pulses", 32'(pulses_seen - p0), 32'd0);

    // Reset in the middle of tracking, then hold inputs
    apply(4'b1101, pat[3], 13, 0);
    rst_pulse(3);
    p0 = pulses_seen;
    apply(4'b1101, pat[3], 24, 0);
    #1;
    chk("t5_pulses",  32'(pulses_seen - p0),        32'd1);
    chk("t5_latency", 32'(last_pulse_cyc - rel_cyc), 32'd19);

    // clr on the capture edge: payload still reported, digits cleared
    p0 = pulses_seen;
    apply(4'b0111, pat[5], 30, S + 3);
    #1;
    chk("t6_pulses",    32'(pulses_seen - p0), 32'd1);
    chk("t6_digit_val", 32'(digit_val),        32'd0);
    chk("t6_digit_ok",  32'(digit_ok),         32'd0);
    chk("t6_upd_val",   32'(upd_val),          32'h5);

    // Randomised runs
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) ra = 4'($urandom);
      else ra = ~(4'(4'b0001 << $urandom_range(0, 3)));
      r = $urandom_range(0, 9);
      if (r < 7)       rs = pat[$urandom_range(0, 15)];
      else if (r == 7) rs = 7'h7F;
      else             rs = 7'($urandom);
      rl = $urandom_range(1, 30);
      rc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rl) : 0;
      apply(ra, rs, rl, rc);
    end

    apply(4'hF, 7'h7F, 40, 0);
    #1;
    chk("final_queue_empty", 32'(expq.size()),  32'd0);
    chk("final_pulse_count", 32'(pulses_seen),  32'(pulses_exp));
    chk("final_digit_val",   32'(digit_val),    32'(m_dval()));
    chk("final_digit_ok",    32'(digit_ok),     32'(m_ok));
`ifdef SEG7_ERR_CNT_EN
    chk("final_err_cnt",     32'(err_cnt),      32'(m_ecnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digit positions (2..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16: cycles an anode/segment pair must hold before capture (>=2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port an, input, DIGITS bits: active-low anode strobes; bit i low selects digit i.
REQ-006 SHALL have port seg, input, 7 bits: active-low segments; bit6=a through bit0=g.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of all captured digits.
REQ-008 SHALL have port digit_val, output, 4*DIGITS bits: last captured hex value per digit; digit i in bits [4i+3:4i].
REQ-009 SHALL have port digit_ok, output, DIGITS bits: digit i holds a valid decoded value.
REQ-010 SHALL have port upd_valid, output, 1 bit: single-cycle capture pulse.
REQ-011 SHALL have port upd_idx, output, 3 bits: digit index of the capture.
REQ-012 SHALL have port upd_val, output, 4 bits: decoded value of the capture.
REQ-013 SHALL have port upd_err, output, 1 bit: capture pattern not recognised; qualified by upd_valid.

Function
REQ-014 SHALL pass an and seg through a 2-flop synchroniser before any other logic.
REQ-015 SHALL decode active-low patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-016 SHALL treat 1111111 as blank: capture clears digit_ok[i], keeps digit_val[i], upd_err=0, upd_val=0.
REQ-017 SHALL treat any other pattern as an error: digit_ok[i]=0, digit_val[i] unchanged, upd_err=1, upd_val=0.
REQ-018 SHALL implement FSM IDLE, TRACK, HOLD; stability counter width clog2(STABLE_CYCLES).
REQ-019 IDLE: synchronised an has zero or more than one low bit; no capture; exit to TRACK when exactly one bit is low.
REQ-020 TRACK: counter increments each cycle the synchronised {an,seg} equals the registered copy; any difference reloads the counter to 0 and stays in TRACK.
REQ-021 TRACK -> HOLD when counter reaches STABLE_CYCLES-1; upd_valid pulses that cycle and digit_val/digit_ok update on the same edge.
REQ-022 HOLD: no further capture; any change in {an,seg} -> TRACK with counter 0; invalid an -> IDLE from TRACK or HOLD.
REQ-023 Latency: inputs held constant from rising edge t (valid one-hot an) SHALL produce upd_valid high in the cycle after edge t+STABLE_CYCLES+2.
REQ-024 upd_idx SHALL equal the index of the low an bit; upper bits are zero when DIGITS<8.
REQ-025 clr SHALL zero digit_val and digit_ok; clr and capture in the same cycle: clr wins, upd_valid still pulses with its normal payload.

Reset
REQ-026 rst_n low SHALL asynchronously force the FSM to IDLE and zero the synchronisers, counter, digit_val, digit_ok, upd_valid, upd_idx, upd_val and upd_err.
REQ-027 Reset mid-TRACK SHALL discard the partial count; after release capture needs a full STABLE_CYCLES+3 cycle window.

Configuration
REQ-028 With macro SEG7_ERR_CNT_EN defined, SHALL add output err_cnt, 8 bits, counting upd_err captures, saturating at 255, cleared by rst_n and clr.
REQ-029 Without SEG7_ERR_CNT_EN, err_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16 pattern constants, SEG_BLANK and the FSM state enum.
REQ-031 Pattern-to-value lookup SHALL be sub-module seg7_pattern_lut (combinational; outputs value, hit, blank).

Verification
REQ-032 an=1110, seg=0010010 held 20 cycles -> one upd_valid, upd_idx=0, upd_val=2, digit_val[3:0]=2, digit_ok[0]=1.
REQ-033 Scan 4 digits with 1,A,d,F, 30 cycles each -> digit_val=16'hFDA1, digit_ok=1111, exactly 4 pulses.
REQ-034 an=1011, seg=1010101 -> upd_err=1, upd_idx=2, digit_ok[2]=0; err_cnt=1 with SEG7_ERR_CNT_EN.
REQ-035 seg toggled every 8 cycles (STABLE_CYCLES=16); an=1100 held -> zero upd_valid pulses.
REQ-036 rst_n low at TRACK count 10, released, inputs held -> all outputs 0, then capture exactly 19 cycles after release.
REQ-037 clr asserted in the same cycle as upd_valid -> digit_val=0, digit_ok=0, upd_valid=1 with its normal payload.
